data_mem_responder: RTL and testbench
=====================================

// Module: data_mem_responder
// PURPOSE
//  Memory-side responder for the multi-cycle RISC-V core: services the MemRead/MemWrite/BE requests the
//  control unit issues in the MEM state. Owns a word-organised data RAM, performs byte-lane alignment on
//  stores, lane extraction plus sign/zero extension on loads, and answers after a fixed latency
//  with a valid/ready response handshake. Sits between the datapath's ALU-result address and the WB mux.
// PARAMETERS
//  ADDR_WIDTH  10  word-address bits; depth = 2**ADDR_WIDTH 32-bit words
//  LATENCY     2   cycles from accept to resp_valid (legal 1..15)
// PORTS
//  CLK         in   1   clock, rising edge
//  RSTn        in   1   reset, asynchronous, active-low
//  req_valid   in   1   request present
//  req_ready   out  1   responder can accept (IDLE only)
//  MemRead     in   1   load request
//  MemWrite    in   1   store request
//  ADDR        in   32  byte address; bits [ADDR_WIDTH+1:2] select word, [1:0] select lane
//  BE          in   4   access size: 0001 byte, 0011 half, 1111 word (unshifted, as decoded)
//  SignExt     in   1   loads: 1 = sign-extend (LB/LH), 0 = zero-extend (LBU/LHU)
//  WDATA       in   32  store data, right-justified
//  resp_valid  out  1   response present; held until resp_ready
//  resp_ready  in   1   consumer takes response
//  RDATA       out  32  load result, extended; 0 for stores and errors
//  resp_err    out  1   request was illegal; no RAM side effect
// BEHAVIOUR
//  - Reset (async assert, sync release): state IDLE, req_ready=1 only after release, resp_valid=0,
//    RDATA=0, resp_err=0, counter=0. RAM contents not reset. Reset mid-request abandons it; no write.
//  - FSM IDLE -> WAIT -> RESP -> IDLE.
//    IDLE: req_ready=1; req_valid&&req_ready captures ADDR/BE/WDATA/MemRead/MemWrite/SignExt, loads
//      counter=LATENCY-1; go WAIT (LATENCY>1) or RESP directly (LATENCY==1).
//    WAIT: req_ready=0, counter decrements; at counter==1 go RESP. Inputs ignored.
//    RESP: resp_valid=1, RDATA/resp_err stable; resp_valid&&resp_ready -> IDLE (req_ready=1 next cycle,
//      no back-to-back accept in the handshake cycle). Accept-to-resp_valid = exactly LATENCY cycles.
//  - RAM write / read occur on the single edge entering RESP; read uses pre-write contents (no R+W case).
//  - Store: lane mask = BE << ADDR[1:0]; data = WDATA << 8*ADDR[1:0]; only masked bytes change.
//  - Load: word >> 8*ADDR[1:0], keep 8/16/32 bits per BE, extend per SignExt (ignored for word).
//  - Error (resp_err=1, RDATA=0, no write): BE not in {0001,0011,1111}; half with ADDR[0]=1; word with
//    ADDR[1:0]!=0; MemRead==MemWrite (both or neither). Error still takes full LATENCY and handshake.
//  - ADDR bits above ADDR_WIDTH+1 ignored (address wraps modulo depth).
//  - Store response: resp_valid=1, RDATA=0, resp_err=0.
// STRUCTURE
//  - Shared package: BE_BYTE/BE_HALF/BE_WORD constants, state encoding (IDLE/WAIT/RESP) used by both
//    this block and the control unit's BE decode.
//  - One sub-module: mem_lane_align (combinational: store mask/data shift, load extract/extend,
//    misalignment check). RAM array and FSM live in the top.
// TESTING
//  1. SW 0xDEADBEEF @0x10, then LW @0x10 -> store resp RDATA=0 err=0; load RDATA=0xDEADBEEF after exactly
//     LATENCY cycles from accept.
//  2. After (1): SB 0x7F @0x13, LB @0x13 -> 0x0000007F; LBU @0x12 -> 0x000000AD; LB @0x12 -> 0xFFFFFFAD;
//     LW @0x10 -> 0x7FADBEEF.
//  3. LH @0x11 and LW @0x12 and BE=0101 -> resp_err=1, RDATA=0; subsequent LW @0x10 unchanged 0x7FADBEEF.
//  4. Hold resp_ready=0 for 5 cycles in RESP -> resp_valid, RDATA stay stable, req_ready=0; new req_valid
//     ignored until one cycle after handshake.
//  5. Assert RSTn=0 during WAIT of a SW @0x20 -> outputs zero immediately, req_ready=1 after release;
//     LW @0x20 returns prior contents (write dropped).
//  6. ADDR=0x1000_0010 with ADDR_WIDTH=10 -> aliases word 4; MemRead=MemWrite=1 -> resp_err=1, no write.

Source files
------------

// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory responder and the control unit's BE decode:
// access-size encodings, responder FSM states and the store lane-mask helper.
package data_mem_responder_pkg;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic [3:0] lane_mask(input logic [3:0] be, input logic [1:0] lane);
    logic [6:0] wide;
    wide = {3'b000, be} << lane;
    return wide[3:0];
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: store mask/data placement, load lane extraction with
// sign/zero extension, and legality check of the access.
module mem_lane_align
  import data_mem_responder_pkg::*;
(
  input  logic [3:0]  be,
  input  logic [1:0]  lane,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  wmask,
  output logic [31:0] wdata_sh,
  output logic [31:0] rdata,
  output logic        err
);

  logic [31:0] shifted_s;
  logic        size_err_s;

  // load extraction and per-size alignment check
  always_comb begin
    size_err_s = 1'b0;
    rdata      = 32'd0;
    shifted_s  = rword >> {lane, 3'b000};
    case (be)
      BE_BYTE: begin
        size_err_s = 1'b0;
        rdata      = {{24{sign_ext & shifted_s[7]}}, shifted_s[7:0]};
      end
      BE_HALF: begin
        size_err_s = lane[0];
        rdata      = {{16{sign_ext & shifted_s[15]}}, shifted_s[15:0]};
      end
      BE_WORD: begin
        size_err_s = (lane != 2'd0);
        rdata      = shifted_s;
      end
      default: begin
        size_err_s = 1'b1;
        rdata      = 32'd0;
      end
    endcase
  end

  // a request must be exactly one of load or store
  assign err      = size_err_s | (mem_read == mem_write);
  assign wmask    = lane_mask(be, lane);
  assign wdata_sh = wdata << {lane, 3'b000};

endmodule

// File: rtl/data_mem_responder.sv
// Word-organised data RAM answering MEM-stage load/store requests after a fixed latency,
// with a valid/ready response handshake.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] ADDR,
  input  logic [3:0]  BE,
  input  logic        SignExt,
  input  logic [31:0] WDATA,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] RDATA,
  output logic        resp_err
);

  localparam int DEPTH = 32'd1 << ADDR_WIDTH;

  state_t                state_r, state_s;
  logic [3:0]            cnt_r;
  logic [ADDR_WIDTH+1:0] addr_r, op_addr_s;
  logic [3:0]            be_r, op_be_s;
  logic [31:0]           wdata_r, op_wdata_s;
  logic                  rd_r, wr_r, sx_r, op_rd_s, op_wr_s, op_sx_s;
  logic                  req_ready_r, resp_valid_r, err_r;
  logic [31:0]           rdata_r;
  logic                  accept_s, enter_resp_s, we_s;
  logic [31:0]           mem_r [0:DEPTH-1];
  logic [ADDR_WIDTH-1:0] widx_s;
  logic [31:0]           rword_s, wdata_sh_s, ext_s;
  logic [3:0]            wmask_s;
  logic                  err_s;
  logic                  unused_addr_s;

  assign unused_addr_s = ^ADDR[31:ADDR_WIDTH+2];

  // with LATENCY==1 RESP is entered on the accept edge, so the live request is the operand
  always_comb begin
    if (state_r == IDLE) begin
      op_addr_s  = ADDR[ADDR_WIDTH+1:0];
      op_be_s    = BE;
      op_wdata_s = WDATA;
      op_rd_s    = MemRead;
      op_wr_s    = MemWrite;
      op_sx_s    = SignExt;
    end else begin
      op_addr_s  = addr_r;
      op_be_s    = be_r;
      op_wdata_s = wdata_r;
      op_rd_s    = rd_r;
      op_wr_s    = wr_r;
      op_sx_s    = sx_r;
    end
  end

  // next-state logic
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_valid && req_ready_r) begin
          accept_s = 1'b1;
          state_s  = (LATENCY == 32'sd1) ? RESP : WAIT;
        end else begin
          state_s  = IDLE;
        end
      end
      WAIT: begin
        if (cnt_r == 4'd1) state_s = RESP;
        else               state_s = WAIT;
      end
      RESP: begin
        if (resp_ready) state_s = IDLE;
        else            state_s = RESP;
      end
      default: state_s = IDLE;
    endcase
  end

  assign widx_s       = op_addr_s[ADDR_WIDTH+1:2];
  assign rword_s      = mem_r[widx_s];
  assign enter_resp_s = (state_s == RESP) && (state_r != RESP);
  assign we_s         = enter_resp_s && op_wr_s && !err_s;

  mem_lane_align u_align (
    .be       (op_be_s),
    .lane     (op_addr_s[1:0]),
    .mem_read (op_rd_s),
    .mem_write(op_wr_s),
    .sign_ext (op_sx_s),
    .wdata    (op_wdata_s),
    .rword    (rword_s),
    .wmask    (wmask_s),
    .wdata_sh (wdata_sh_s),
    .rdata    (ext_s),
    .err      (err_s)
  );

  // FSM, request capture, latency counter and registered response
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_r      <= IDLE;
      cnt_r        <= 4'd0;
      addr_r       <= '0;
      be_r         <= 4'd0;
      wdata_r      <= 32'd0;
      rd_r         <= 1'b0;
      wr_r         <= 1'b0;
      sx_r         <= 1'b0;
      req_ready_r  <= 1'b0;
      resp_valid_r <= 1'b0;
      rdata_r      <= 32'd0;
      err_r        <= 1'b0;
    end else begin
      state_r      <= state_s;
      req_ready_r  <= (state_s == IDLE);
      resp_valid_r <= (state_s == RESP);
      if (accept_s) begin
        addr_r  <= ADDR[ADDR_WIDTH+1:0];
        be_r    <= BE;
        wdata_r <= WDATA;
        rd_r    <= MemRead;
        wr_r    <= MemWrite;
        sx_r    <= SignExt;
        cnt_r   <= 4'(LATENCY - 32'sd1);
      end else if (state_r == WAIT) begin
        cnt_r   <= cnt_r - 4'd1;
      end
      if (enter_resp_s) begin
        rdata_r <= (op_rd_s && !err_s) ? ext_s : 32'd0;
        err_r   <= err_s;
      end else if ((state_r == RESP) && resp_ready) begin
        rdata_r <= 32'd0;
        err_r   <= 1'b0;
      end
    end
  end

  // byte-masked RAM write; contents are deliberately not reset
  always_ff @(posedge CLK) begin
    if (we_s) begin
      for (int i = 0; i < 4; i++) begin
        if (wmask_s[i]) mem_r[widx_s][8*i +: 8] <= wdata_sh_s[8*i +: 8];
      end
    end
  end

  assign req_ready  = req_ready_r;
  assign resp_valid = resp_valid_r;
  assign RDATA      = rdata_r;
  assign resp_err   = err_r;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench: directed vector table, reset/backpressure sequences and randomized
// traffic compared against a byte-array memory model.
module tb_data_mem_responder;

  localparam int AW  = 10;
  localparam int LAT = 2;

  logic        CLK = 1'b0, RSTn = 1'b0;
  logic        req_valid = 1'b0, MemRead = 1'b0, MemWrite = 1'b0, SignExt = 1'b0;
  logic        resp_ready = 1'b0;
  logic [31:0] ADDR = 32'd0, WDATA = 32'd0;
  logic [3:0]  BE = 4'd0;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] RDATA;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] ref_mem [0:4095];

  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic        sx;
    logic [31:0] wd;
    int          hold;
    logic [31:0] exp_rd;
    logic        exp_er;
  } vec_t;
  vec_t tbl[$];

  data_mem_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
    .CLK(CLK), .RSTn(RSTn), .req_valid(req_valid), .req_ready(req_ready),
    .MemRead(MemRead), .MemWrite(MemWrite), .ADDR(ADDR), .BE(BE), .SignExt(SignExt),
    .WDATA(WDATA), .resp_valid(resp_valid), .resp_ready(resp_ready), .RDATA(RDATA),
    .resp_err(resp_err)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no end expected end");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Reference: memory as a flat byte array, loads assembled byte by byte.
  task automatic model(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [3:0] be, input logic sx, input logic [31:0] wd,
                       output logic [31:0] rdata, output logic err);
    int size, base;
    logic [63:0] val;
    size = (be == 4'b0001) ? 1 : (be == 4'b0011) ? 2 : (be == 4'b1111) ? 4 : 0;
    err  = (rd == wr) || (size == 0) || (size == 2 && addr[0]) ||
           (size == 4 && addr[1:0] != 2'd0);
    base = int'(addr % 32'd4096);
    rdata = 32'd0;
    if (!err && wr) begin
      for (int i = 0; i < size; i++) ref_mem[(base + i) % 4096] = wd[8*i +: 8];
    end else if (!err) begin
      val = 64'd0;
      for (int i = 0; i < size; i++) val = val + (64'(ref_mem[(base + i) % 4096]) << (8 * i));
      if (sx && size < 4 && val[8*size-1]) val = val - (64'd1 << (8 * size));
      rdata = val[31:0];
    end
  endtask

  task automatic transact(input string name, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [3:0] be, input logic sx,
                          input logic [31:0] wd, input int hold, input logic use_exp,
                          input logic [31:0] exp_rd, input logic exp_er);
    logic [31:0] m_rd, e_rd;
    logic        m_er, e_er;
    int          cnt;
    model(rd, wr, addr, be, sx, wd, m_rd, m_er);
    e_rd = use_exp ? exp_rd : m_rd;
    e_er = use_exp ? exp_er : m_er;
    MemRead = rd; MemWrite = wr; ADDR = addr; BE = be; SignExt = sx; WDATA = wd;
    req_valid = 1'b1;
    cnt = 0;
    while (!req_ready && cnt < 50) begin @(posedge CLK); #1; cnt++; end
    check({name, " req_ready"}, {31'd0, req_ready}, 32'd1);
    @(posedge CLK); #1;
    req_valid = 1'b0;
    ADDR = $urandom; WDATA = $urandom; BE = 4'($urandom);
    MemRead = 1'($urandom); MemWrite = 1'($urandom); SignExt = 1'($urandom);
    cnt = 1;
    while (!resp_valid && cnt < 40) begin @(posedge CLK); #1; cnt++; end
    check({name, " latency"}, 32'(cnt), 32'(LAT));
    check({name, " rdata"}, RDATA, e_rd);
    check({name, " err"}, {31'd0, resp_err}, {31'd0, e_er});
    for (int h = 0; h < hold; h++) begin
      req_valid = 1'b1; MemWrite = 1'b1; MemRead = 1'b0; BE = 4'b1111;
      ADDR = 32'h100 + {26'd0, 4'($urandom_range(0, 15)), 2'b00}; WDATA = $urandom;
      @(posedge CLK); #1;
      check({name, " hold valid"}, {31'd0, resp_valid}, 32'd1);
      check({name, " hold rdata"}, RDATA, e_rd);
      check({name, " hold req_ready"}, {31'd0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge CLK); #1;
    resp_ready = 1'b0;
    req_valid  = 1'b0;
    check({name, " post valid"}, {31'd0, resp_valid}, 32'd0);
    check({name, " post req_ready"}, {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    logic [3:0] rbe;
    logic       rrd, rwr;
    int         k, j;

    tbl.push_back('{"sw10",   1'b0, 1'b1, 32'h10, 4'b1111, 1'b0, 32'hDEADBEEF, 0, 32'h0, 1'b0});
    tbl.push_back('{"lw10",   1'b1, 1'b0, 32'h10, 4'b1111, 1'b0, 32'h0, 0, 32'hDEADBEEF, 1'b0});
    tbl.push_back('{"sb13",   1'b0, 1'b1, 32'h13, 4'b0001, 1'b0, 32'h7F, 0, 32'h0, 1'b0});
    tbl.push_back('{"lb13",   1'b1, 1'b0, 32'h13, 4'b0001, 1'b1, 32'h0, 0, 32'h0000007F, 1'b0});
    tbl.push_back('{"lbu12",  1'b1, 1'b0, 32'h12, 4'b0001, 1'b0, 32'h0, 0, 32'h000000AD, 1'b0});
    tbl.push_back('{"lb12",   1'b1, 1'b0, 32'h12, 4'b0001, 1'b1, 32'h0, 0, 32'hFFFFFFAD, 1'b0});
    tbl.push_back('{"lw10b",  1'b1, 1'b0, 32'h10, 4'b1111, 1'b0, 32'h0, 5, 32'h7FADBEEF, 1'b0});
    tbl.push_back('{"lh11",   1'b1, 1'b0, 32'h11, 4'b0011, 1'b1, 32'h0, 0, 32'h0, 1'b1});
    tbl.push_back('{"lw12",   1'b1, 1'b0, 32'h12, 4'b1111, 1'b0, 32'h0, 0, 32'h0, 1'b1});
    tbl.push_back('{"be0101", 1'b1, 1'b0, 32'h10, 4'b0101, 1'b0, 32'h0, 0, 32'h0, 1'b1});
    tbl.push_back('{"lw10c",  1'b1, 1'b0, 32'h10, 4'b1111, 1'b0, 32'h0, 0, 32'h7FADBEEF, 1'b0});
    tbl.push_back('{"alias",  1'b1, 1'b0, 32'h1000_0010, 4'b1111, 1'b0, 32'h0, 0, 32'h7FADBEEF, 1'b0});
    tbl.push_back('{"rdwr",   1'b1, 1'b1, 32'h10, 4'b1111, 1'b0, 32'h12345678, 0, 32'h0, 1'b1});
    tbl.push_back('{"lw10d",  1'b1, 1'b0, 32'h10, 4'b1111, 1'b0, 32'h0, 0, 32'h7FADBEEF, 1'b0});
    tbl.push_back('{"none",   1'b0, 1'b0, 32'h10, 4'b1111, 1'b0, 32'h0, 0, 32'h0, 1'b1});
    tbl.push_back('{"sh16",   1'b0, 1'b1, 32'h16, 4'b0011, 1'b0, 32'h0000A5C3, 0, 32'h0, 1'b0});
    tbl.push_back('{"lh16",   1'b1, 1'b0, 32'h16, 4'b0011, 1'b1, 32'h0, 0, 32'hFFFFA5C3, 1'b0});
    tbl.push_back('{"lhu16",  1'b1, 1'b0, 32'h16, 4'b0011, 1'b0, 32'h0, 0, 32'h0000A5C3, 1'b0});

    #1;
    check("rst req_ready", {31'd0, req_ready}, 32'd0);
    check("rst resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst rdata", RDATA, 32'd0);
    check("rst err", {31'd0, resp_err}, 32'd0);
    #21 RSTn = 1'b1;
    @(posedge CLK); #1;
    check("release req_ready", {31'd0, req_ready}, 32'd1);

    foreach (tbl[i])
      transact(tbl[i].name, tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].be, tbl[i].sx,
               tbl[i].wd, tbl[i].hold, 1'b1, tbl[i].exp_rd, tbl[i].exp_er);

    // reset during WAIT of a store must drop the write
    transact("sw20", 1'b0, 1'b1, 32'h20, 4'b1111, 1'b0, 32'h11223344, 0, 1'b0, 32'h0, 1'b0);
    MemRead = 1'b0; MemWrite = 1'b1; ADDR = 32'h20; BE = 4'b1111; WDATA = 32'hCAFEF00D;
    req_valid = 1'b1;
    @(posedge CLK); #1;
    req_valid = 1'b0;
    RSTn = 1'b0;
    #1;
    check("midrst req_ready", {31'd0, req_ready}, 32'd0);
    check("midrst resp_valid", {31'd0, resp_valid}, 32'd0);
    check("midrst rdata", RDATA, 32'd0);
    check("midrst err", {31'd0, resp_err}, 32'd0);
    @(posedge CLK); @(posedge CLK); #2;
    RSTn = 1'b1;
    @(posedge CLK); #1;
    check("midrst release req_ready", {31'd0, req_ready}, 32'd1);
    transact("lw20", 1'b1, 1'b0, 32'h20, 4'b1111, 1'b0, 32'h0, 0, 1'b1, 32'h11223344, 1'b0);

    // randomized traffic over a pre-initialised region, with aliased upper address bits
    for (int w = 0; w < 16; w++)
      transact("prefill", 1'b0, 1'b1, 32'h100 + 32'(4 * w), 4'b1111, 1'b0, $urandom, 0,
               1'b0, 32'h0, 1'b0);
    for (int n = 0; n < 150; n++) begin
      k = $urandom_range(0, 9);
      rrd = (k < 4) || (k == 8);
      rwr = (k >= 4 && k < 8) || (k == 8);
      j = $urandom_range(0, 7);
      case (j)
        0, 1, 7: rbe = 4'b0001;
        2, 3:    rbe = 4'b0011;
        4, 5:    rbe = 4'b1111;
        default: rbe = 4'($urandom);
      endcase
      transact("rand", rrd, rwr, {20'($urandom), 12'h100 + 12'($urandom_range(0, 63))}, rbe,
               1'($urandom), $urandom, $urandom_range(0, 2), 1'b0, 32'h0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
